// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl_if                                          |
// | Description : Bundle between the ID stage / memory system and the hazard   |
// |               controller. The pipeline side (master) drives ID instruction |
// |               fields, branch and memory status. The controller (slave)     |
// |               returns stall, flush, forwarding, stage-valid and counters.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
  parameter int STAGES     = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  localparam int SEL_W = $clog2(STAGES + 1);

  logic                  id_valid;
  logic                  id_rs_en;
  logic                  id_rt_en;
  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic [REG_ADDR_W-1:0] id_rt_addr;
  logic [REG_ADDR_W-1:0] id_dst_addr;
  logic                  id_reg_write;
  logic                  id_is_load;
  logic                  id_is_mem;
  logic                  branch_taken;
  logic                  mem_ready;

  logic                  stall_if;
  logic                  stall_id;
  logic                  flush_id;
  logic [SEL_W-1:0]      fwd_rs_sel;
  logic [SEL_W-1:0]      fwd_rt_sel;
  logic [STAGES-1:0]     stage_valid;
  logic                  wb_commit;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs_en, id_rt_en, id_rs_addr, id_rt_addr, id_dst_addr,
    output id_reg_write, id_is_load, id_is_mem, branch_taken, mem_ready,
    input  stall_if, stall_id, flush_id, fwd_rs_sel, fwd_rt_sel,
    input  stage_valid, wb_commit, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_en, id_rt_en, id_rs_addr, id_rt_addr, id_dst_addr,
    input  id_reg_write, id_is_load, id_is_mem, branch_taken, mem_ready,
    output stall_if, stall_id, flush_id, fwd_rs_sel, fwd_rt_sel,
    output stage_valid, wb_commit, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl                                             |
// | Description : Hazard controller for an in-order pipeline. Tracks the       |
// |               post-ID stages (1=EX, 2=MEM, STAGES=WB), detects RAW hazards |
// |               against the ID sources, generates stall / flush / forwarding |
// |               selects and counts ID stall cycles (saturating).             |
// |               Optional feature macro: FORWARD_EN                           |
// |                 defined   : bypass network present, only load-use stalls   |
// |                 undefined : no bypassing, any in-flight writer stalls      |
// |               STAGES legal range is 2..8.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int STAGES     = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(STAGES + 1);

  // Per-stage entry state, index k = stage k
  logic [STAGES:1]       r_valid;
  logic [STAGES:1]       r_writes;
  logic [STAGES:1]       r_load;
  logic [STAGES:1]       r_mem;
  logic [REG_ADDR_W-1:0] r_dst [1:STAGES];
  logic [CNT_W-1:0]      r_stall_cnt;

  logic [STAGES:1]       w_rs_match;
  logic [STAGES:1]       w_rt_match;
  logic                  w_rs_en;
  logic                  w_rt_en;
  logic                  w_hazard;
  logic                  w_mem_wait;
  logic                  w_branch;
  logic                  w_stall;
  logic                  w_flush;
  logic [SEL_W-1:0]      w_fwd_rs;
  logic [SEL_W-1:0]      w_fwd_rt;
  logic                  w_unused;

  // A bubble in ID never reads registers, so it can neither stall nor forward
  assign w_rs_en = bus.id_valid & bus.id_rs_en;
  assign w_rt_en = bus.id_valid & bus.id_rt_en;

  // Per-stage source match; register 0 is hard-wired and never matches
  for (genvar k = 1; k <= STAGES; k++) begin : g_match
    assign w_rs_match[k] = r_valid[k] & r_writes[k] & w_rs_en &
                           (bus.id_rs_addr != '0) & (bus.id_rs_addr == r_dst[k]);
    assign w_rt_match[k] = r_valid[k] & r_writes[k] & w_rt_en &
                           (bus.id_rt_addr != '0) & (bus.id_rt_addr == r_dst[k]);
  end

`ifdef FORWARD_EN
  // Lowest-numbered (youngest) matching stage wins the bypass mux
  always_comb begin
    w_fwd_rs = '0;
    w_fwd_rt = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (w_rs_match[k]) w_fwd_rs = SEL_W'(k);
      if (w_rt_match[k]) w_fwd_rt = SEL_W'(k);
    end
  end

  // Load data is not available until after MEM, so a load in EX must stall
  assign w_hazard = (w_rs_match[1] | w_rt_match[1]) & r_load[1];
`else
  // No bypass network: consumers wait until the writer has left WB
  assign w_fwd_rs = '0;
  assign w_fwd_rt = '0;
  assign w_hazard = (|w_rs_match) | (|w_rt_match);
`endif

  // Load/mem flags are only consulted at specific stages
  assign w_unused = ^{r_load, r_mem};

  // Priority: memory wait freezes everything, then branch flush, then hazard
  assign w_mem_wait = r_valid[2] & r_mem[2] & ~bus.mem_ready;
  assign w_branch   = bus.branch_taken & r_valid[1];
  assign w_flush    = ~w_mem_wait & w_branch;
  assign w_stall    = w_mem_wait | (~w_branch & w_hazard);

  assign bus.stall_if    = w_stall;
  assign bus.stall_id    = w_stall;
  assign bus.flush_id    = w_flush;
  assign bus.fwd_rs_sel  = w_fwd_rs;
  assign bus.fwd_rt_sel  = w_fwd_rt;
  assign bus.stage_valid = r_valid;
  assign bus.wb_commit   = r_valid[STAGES] & r_writes[STAGES] & ~w_mem_wait;
  assign bus.stall_cnt   = r_stall_cnt;

  // Pipeline entry tracking: hold on memory wait, else shift with ID or bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_writes <= '0;
      r_load   <= '0;
      r_mem    <= '0;
      for (int k = 1; k <= STAGES; k++) r_dst[k] <= '0;
    end else if (!w_mem_wait) begin
      for (int k = 2; k <= STAGES; k++) begin
        r_valid[k]  <= r_valid[k-1];
        r_writes[k] <= r_writes[k-1];
        r_load[k]   <= r_load[k-1];
        r_mem[k]    <= r_mem[k-1];
        r_dst[k]    <= r_dst[k-1];
      end
      if (w_flush || w_stall) begin
        r_valid[1]  <= 1'b0;
        r_writes[1] <= 1'b0;
        r_load[1]   <= 1'b0;
        r_mem[1]    <= 1'b0;
        r_dst[1]    <= '0;
      end else begin
        r_valid[1]  <= bus.id_valid;
        r_writes[1] <= bus.id_reg_write;
        r_load[1]   <= bus.id_is_load;
        r_mem[1]    <= bus.id_is_mem;
        r_dst[1]    <= bus.id_dst_addr;
      end
    end
  end

  // Saturating count of cycles in which ID is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_hazard_ctrl                                          |
// | Description : Self-checking bench for pipe_hazard_ctrl: directed scenarios |
// |               plus randomized traffic against a queue-based model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;
  localparam int S  = 3;
  localparam int AW = 5;
  localparam int CW = 32;

  typedef struct { bit v; bit w; bit ld; bit mem; int dst; } ent_t;
  typedef struct { bit v; bit rs_en; bit rt_en; int rs; int rt; int dst;
                   bit w; bit ld; bit mem; } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_hazard_ctrl_if #(.STAGES(S), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.STAGES(S), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic set_id(input bit v, input bit rs_en, input int rs, input bit rt_en,
                        input int rt, input int dst, input bit w, input bit ld,
                        input bit mem);
    bus.id_valid     = v;
    bus.id_rs_en     = rs_en;
    bus.id_rs_addr   = AW'(rs);
    bus.id_rt_en     = rt_en;
    bus.id_rt_addr   = AW'(rt);
    bus.id_dst_addr  = AW'(dst);
    bus.id_reg_write = w;
    bus.id_is_load   = ld;
    bus.id_is_mem    = mem;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Outputs must be all zero while reset is held, whatever the inputs do
  task automatic test_reset();
    rst = 1'b1;
    set_id(1, 1, 3, 1, 3, 3, 1, 1, 1);
    bus.branch_taken = 1'b1;
    bus.mem_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.wb_commit} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {bus.stall_if, bus.stall_id, bus.flush_id, bus.wb_commit});
    end
    n_checks++;
    if ({bus.fwd_rs_sel, bus.fwd_rt_sel, bus.stage_valid} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: fwd %0d/%0d stage_valid %b required 0",
               bus.fwd_rs_sel, bus.fwd_rt_sel, bus.stage_valid);
    end
    n_checks++;
    if (bus.stall_cnt !== '0) begin
      n_errors++;
      $display("FAIL reset_cnt: got %0d required 0", bus.stall_cnt);
    end
    do_reset();
  endtask

  // add r3 followed immediately by add r4,r3,r3
  task automatic test_raw_alu();
    do_reset();
    @(negedge clk); set_id(1, 1, 1, 1, 2, 3, 1, 0, 0); #1;
    n_checks++;
    if (bus.stall_id !== 1'b0) begin
      n_errors++; $display("FAIL raw_first: stall_id got %b required 0", bus.stall_id);
    end
    @(negedge clk); set_id(1, 1, 3, 1, 3, 4, 1, 0, 0); #1;
`ifdef FORWARD_EN
    n_checks++;
    if ({bus.stall_id, bus.fwd_rs_sel, bus.fwd_rt_sel} !== {1'b0, 2'd1, 2'd1}) begin
      n_errors++;
      $display("FAIL raw_fwd: stall %b rs %0d rt %0d required 0 1 1",
               bus.stall_id, bus.fwd_rs_sel, bus.fwd_rt_sel);
    end
    @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++;
    if ({bus.fwd_rs_sel, bus.fwd_rt_sel, bus.stall_cnt} !== '0) begin
      n_errors++;
      $display("FAIL raw_fwd_after: rs %0d rt %0d cnt %0d required 0 0 0",
               bus.fwd_rs_sel, bus.fwd_rt_sel, bus.stall_cnt);
    end
`else
    for (int c = 0; c < 3; c++) begin
      if (c != 0) begin @(negedge clk); #1; end
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.fwd_rs_sel, bus.fwd_rt_sel} !== {2'b11, 4'b0}) begin
        n_errors++;
        $display("FAIL raw_stall[%0d]: stall %b%b rs %0d rt %0d required 11 0 0", c,
                 bus.stall_if, bus.stall_id, bus.fwd_rs_sel, bus.fwd_rt_sel);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({bus.stall_id, bus.stall_cnt} !== {1'b0, 32'd3}) begin
      n_errors++;
      $display("FAIL raw_release: stall %b cnt %0d required 0 3", bus.stall_id, bus.stall_cnt);
    end
`endif
  endtask

  // lw r5 then add r6,r5,r1
  task automatic test_load_use();
    do_reset();
    @(negedge clk); set_id(1, 1, 2, 0, 0, 5, 1, 1, 1); #1;
    @(negedge clk); set_id(1, 1, 5, 1, 1, 6, 1, 0, 0); #1;
    n_checks++;
    if (bus.stall_id !== 1'b1) begin
      n_errors++; $display("FAIL load_use_stall: got %b required 1", bus.stall_id);
    end
    @(negedge clk); #1;
`ifdef FORWARD_EN
    n_checks++;
    if ({bus.stall_id, bus.fwd_rs_sel, bus.fwd_rt_sel, bus.stall_cnt} !==
        {1'b0, 2'd2, 2'd0, 32'd1}) begin
      n_errors++;
      $display("FAIL load_use_fwd: stall %b rs %0d rt %0d cnt %0d required 0 2 0 1",
               bus.stall_id, bus.fwd_rs_sel, bus.fwd_rt_sel, bus.stall_cnt);
    end
`else
    n_checks++;
    if ({bus.stall_id, bus.fwd_rs_sel, bus.stall_cnt} !== {1'b1, 2'd0, 32'd1}) begin
      n_errors++;
      $display("FAIL load_use_nofwd: stall %b rs %0d cnt %0d required 1 0 1",
               bus.stall_id, bus.fwd_rs_sel, bus.stall_cnt);
    end
`endif
  endtask

  // Taken branch in EX squashes the instruction currently in ID
  task automatic test_branch_flush();
    do_reset();
    @(negedge clk); set_id(1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++;
    if (bus.flush_id !== 1'b0) begin
      n_errors++; $display("FAIL branch_idle: flush got %b required 0", bus.flush_id);
    end
    @(negedge clk); bus.branch_taken = 1'b1; set_id(1, 0, 0, 0, 0, 7, 1, 0, 0); #1;
    n_checks++;
    if ({bus.flush_id, bus.stall_if, bus.stall_id} !== 3'b100) begin
      n_errors++;
      $display("FAIL branch_flush: flush/stall_if/stall_id %b required 100",
               {bus.flush_id, bus.stall_if, bus.stall_id});
    end
    @(negedge clk); bus.branch_taken = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++;
    if ({bus.flush_id, bus.stage_valid} !== {1'b0, 3'b010}) begin
      n_errors++;
      $display("FAIL branch_after: flush %b stage_valid %b required 0 010",
               bus.flush_id, bus.stage_valid);
    end
  endtask

  // Store stuck in MEM for four cycles, optionally cut short by reset
  task automatic test_mem_wait(input bit with_reset);
    do_reset();
    @(negedge clk); set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
    @(negedge clk); set_id(1, 1, 1, 1, 2, 0, 0, 0, 1);
    @(negedge clk); set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); bus.mem_ready = 1'b0; set_id(1, 0, 0, 0, 0, 9, 1, 0, 0); #1;
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.wb_commit, bus.stage_valid} !==
          {4'b1100, 3'b111} || bus.stall_cnt !== CW'(c)) begin
        n_errors++;
        $display("FAIL mem_wait[%0d]: stall %b%b flush %b commit %b sv %b cnt %0d required 11 0 0 111 %0d",
                 c, bus.stall_if, bus.stall_id, bus.flush_id, bus.wb_commit,
                 bus.stage_valid, bus.stall_cnt, c);
      end
      if (with_reset && c == 1) begin
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.stage_valid, bus.stall_if, bus.stall_id} !== 5'b0 || bus.stall_cnt !== '0) begin
          n_errors++;
          $display("FAIL mem_wait_reset: sv %b stall %b%b cnt %0d required 000 00 0",
                   bus.stage_valid, bus.stall_if, bus.stall_id, bus.stall_cnt);
        end
        @(negedge clk); rst = 1'b0; bus.mem_ready = 1'b1;
        set_id(1, 1, 7, 0, 0, 8, 1, 0, 0); #1;
        n_checks++;
        if ({bus.stall_id, bus.wb_commit, bus.stage_valid} !== 5'b0) begin
          n_errors++;
          $display("FAIL post_reset_empty: stall %b commit %b sv %b required 0 0 000",
                   bus.stall_id, bus.wb_commit, bus.stage_valid);
        end
        return;
      end
    end
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    n_checks++;
    if ({bus.stall_id, bus.wb_commit} !== 2'b01 || bus.stall_cnt !== 32'd4) begin
      n_errors++;
      $display("FAIL mem_resume: stall %b commit %b cnt %0d required 0 1 4",
               bus.stall_id, bus.wb_commit, bus.stall_cnt);
    end
  endtask

  // Writer of r0 followed by a reader of r0
  task automatic test_r0();
    do_reset();
    @(negedge clk); set_id(1, 0, 0, 0, 0, 0, 1, 1, 1); #1;
    @(negedge clk); set_id(1, 1, 0, 1, 0, 6, 1, 0, 0); #1;
    n_checks++;
    if ({bus.stall_id, bus.fwd_rs_sel, bus.fwd_rt_sel} !== 5'b0) begin
      n_errors++;
      $display("FAIL r0_no_hazard: stall %b rs %0d rt %0d required 0 0 0",
               bus.stall_id, bus.fwd_rs_sel, bus.fwd_rt_sel);
    end
  endtask

  function automatic bit src_hits(ent_t e, ins_t i, bit en, int a);
    return i.v && en && a != 0 && e.v && e.w && e.dst == a;
  endfunction

  // Random traffic; pipe[0] is stage 1, pipe[S-1] is the writeback stage
  task automatic test_random(input int n);
    ent_t        pipe[$];
    ent_t        blank;
    ent_t        ne;
    ins_t        ins;
    bit          hold;
    bit          br, mr, mem_wait, br_eff, hazard, e_stall, e_flush, e_commit;
    int          e_rs, e_rt;
    logic [S-1:0] e_sv;
    int unsigned cnt;
    do_reset();
    blank = '{v: 0, w: 0, ld: 0, mem: 0, dst: 0};
    pipe = {};
    repeat (S) pipe.push_back(blank);
    cnt  = 0;
    hold = 0;
    ins  = '{default: 0};
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (!hold) begin
        ins = '{default: 0};
        if ($urandom_range(0, 99) < 85) begin
          ins.v     = 1;
          ins.rs_en = $urandom_range(0, 1);
          ins.rt_en = $urandom_range(0, 1);
          ins.rs    = $urandom_range(0, 3);
          ins.rt    = $urandom_range(0, 3);
          ins.dst   = $urandom_range(0, 3);
          ins.w     = ($urandom_range(0, 99) < 60);
          if ($urandom_range(0, 99) < 25) begin ins.ld = 1; ins.w = 1; ins.mem = 1; end
          else if ($urandom_range(0, 99) < 15) begin ins.mem = 1; ins.w = 0; end
        end
      end
      br = ($urandom_range(0, 99) < 15);
      mr = ($urandom_range(0, 99) < 70);
      set_id(ins.v, ins.rs_en, ins.rs, ins.rt_en, ins.rt, ins.dst, ins.w, ins.ld, ins.mem);
      bus.branch_taken = br;
      bus.mem_ready    = mr;
      #1;
      mem_wait = pipe[1].v && pipe[1].mem && !mr;
      br_eff   = br && pipe[0].v;
      e_rs = 0; e_rt = 0; hazard = 0;
      for (int k = S; k >= 1; k--) begin
        if (src_hits(pipe[k-1], ins, ins.rs_en, ins.rs)) e_rs = k;
        if (src_hits(pipe[k-1], ins, ins.rt_en, ins.rt)) e_rt = k;
      end
`ifdef FORWARD_EN
      hazard = (e_rs == 1 || e_rt == 1) && pipe[0].ld;
`else
      hazard = (e_rs != 0 || e_rt != 0);
      e_rs = 0; e_rt = 0;
`endif
      e_stall  = mem_wait || (!br_eff && hazard);
      e_flush  = !mem_wait && br_eff;
      e_commit = pipe[S-1].v && pipe[S-1].w && !mem_wait;
      for (int k = 0; k < S; k++) e_sv[k] = pipe[k].v;
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.wb_commit} !==
          {e_stall, e_stall, e_flush, e_commit}) begin
        n_errors++;
        $display("FAIL rand_ctrl @%0d: stall_if/id flush commit %b required %b", t,
                 {bus.stall_if, bus.stall_id, bus.flush_id, bus.wb_commit},
                 {e_stall, e_stall, e_flush, e_commit});
      end
      n_checks++;
      if (bus.fwd_rs_sel !== 2'(e_rs) || bus.fwd_rt_sel !== 2'(e_rt)) begin
        n_errors++;
        $display("FAIL rand_fwd @%0d: rs %0d rt %0d required %0d %0d", t,
                 bus.fwd_rs_sel, bus.fwd_rt_sel, e_rs, e_rt);
      end
      n_checks++;
      if (bus.stage_valid !== e_sv || bus.stall_cnt !== cnt) begin
        n_errors++;
        $display("FAIL rand_state @%0d: sv %b cnt %0d required %b %0d", t,
                 bus.stage_valid, bus.stall_cnt, e_sv, cnt);
      end
      if (!mem_wait) begin
        ne = blank;
        if (!e_stall && !e_flush)
          ne = '{v: ins.v, w: ins.w, ld: ins.ld, mem: ins.mem, dst: ins.dst};
        void'(pipe.pop_back());
        pipe.push_front(ne);
      end
      if (e_stall && cnt != 32'hFFFF_FFFF) cnt++;
      hold = e_stall;
    end
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b1;
    test_reset();
    test_raw_alu();
    test_load_use();
    test_branch_flush();
    test_mem_wait(1'b0);
    test_mem_wait(1'b1);
    test_r0();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 3, post-ID stage count (1=EX, 2=MEM, STAGES=WB); legal range 2..8.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter CNT_W, default 32, stall counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 id_valid  input  1  ID holds a real instruction.
REQ-007 id_rs_en, id_rt_en  input  1 each  source reads enabled.
REQ-008 id_rs_addr, id_rt_addr, id_dst_addr  input  REG_ADDR_W each  source and destination addresses.
REQ-009 id_reg_write, id_is_load, id_is_mem  input  1 each  ID instruction writes a register / is a load / accesses memory.
REQ-010 branch_taken  input  1  EX instruction (entry 1) redirects PC.
REQ-011 mem_ready  input  1  memory completes the MEM-stage access this cycle.
REQ-012 stall_if, stall_id  output  1 each  hold PC / hold ID register.
REQ-013 flush_id  output  1  replace the ID instruction with a bubble.
REQ-014 fwd_rs_sel, fwd_rt_sel  output  clog2(STAGES+1) each  0=regfile, k=forward from stage k.
REQ-015 stage_valid  output  STAGES  bit k-1 = entry k valid.
REQ-016 wb_commit  output  1  entry STAGES writes regfile this cycle.
REQ-017 stall_cnt  output  CNT_W  cycles with stall_id high.

Function
REQ-018 SHALL keep per-stage entry {valid, dst, writes, is_load, is_mem}, entries 1..STAGES.
REQ-019 Match at stage k: entry valid, writes, src enabled, src!=0, src==dst; register 0 never matches.
REQ-020 mem_wait = entry 2 valid & is_mem & !mem_ready; when high, all entries hold, stall_if=stall_id=1, flush_id=0, wb_commit=0.
REQ-021 Else if branch_taken & entry 1 valid: flush_id=1, stall_if=stall_id=0, entry 1 <= bubble, entries k<=k-1 for k>=2.
REQ-022 Else if hazard (REQ-026/027): stall_if=stall_id=1, entry 1 <= bubble, entries k<=k-1 for k>=2.
REQ-023 Else advance: entry 1 <= ID fields with valid=id_valid, entries k<=k-1.
REQ-024 Priority mem_wait > branch > hazard; a branch_taken held during mem_wait SHALL take effect on the first advancing cycle.
REQ-025 wb_commit = entry STAGES valid & writes & !mem_wait.
REQ-026 fwd_*_sel SHALL select the lowest-numbered matching stage, else 0; combinational, same cycle.
REQ-027 stall_cnt SHALL increment each cycle stall_id=1 and saturate at all-ones.

Reset
REQ-028 rst SHALL asynchronously clear all entries, stall_cnt=0; while asserted all outputs 0.
REQ-029 Reset mid-stall or mid-mem_wait SHALL abandon it; first cycle after release behaves as empty pipeline.

Configuration
REQ-030 Macro FORWARD_EN defined: hazard = match at stage 1 with is_load (load-use, one stall cycle); all other matches forwarded per REQ-026; loads at stage>=2 forward.
REQ-031 FORWARD_EN undefined: hazard = match at any stage 1..STAGES (no regfile write-through); fwd_*_sel tied 0.

Verification
REQ-032 FORWARD_EN, add r3 then add r4,r3,r3 back-to-back -> no stall, fwd_rs_sel=fwd_rt_sel=1 for one cycle.
REQ-033 FORWARD_EN, lw r5 then add r6,r5,r1 -> stall_id=1 exactly 1 cycle, then fwd_rs_sel=2, stall_cnt=1.
REQ-034 No FORWARD_EN, add r3 then use r3 -> stall_id=1 for 3 cycles, stall_cnt=3, fwd_*_sel=0 throughout.
REQ-035 branch_taken with entry 1 valid -> flush_id=1 one cycle, stage_valid[0]=0 next cycle.
REQ-036 sw in MEM, mem_ready=0 for 4 cycles -> stall_if/stall_id high 4 cycles, stage_valid frozen, wb_commit=0, then resumes.
REQ-037 Source r0 after writer of r0 -> no stall; rst pulse during REQ-036 wait -> stage_valid=0, stall_cnt=0 immediately.
